// File: rtl/bw_nested_pic_if.sv
// I/O bus bundle for the BlackWidow nested PIC: cycle/strobe handshake,
// address/data and the ack/volatile responses.
interface bw_nested_pic_if;
    logic        cyc_i;
    logic        stb_i;
    logic        wr_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic        ack_o;
    logic [31:0] dat_o;
    logic        vol_o;

    modport master (
        output cyc_i, stb_i, wr_i, adr_i, dat_i,
        input  ack_o, dat_o, vol_o
    );

    modport slave (
        input  cyc_i, stb_i, wr_i, adr_i, dat_i,
        output ack_o, dat_o, vol_o
    );
endinterface

// File: rtl/bw_nested_pic.sv
// Priority-level nested interrupt controller: per-source level/cause/enable/sense,
// claim/EOI in-service tracking, winner must exceed the running level.
module bw_nested_pic #(
    parameter logic [31:0] pIOAddress = 32'hFF95_0000,
    parameter int          NIRQ       = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bw_nested_pic_if.slave     bus,
    input  logic [NIRQ-1:0]    irq_i,
    output logic [3:0]         irqo,
    output logic [7:0]         causeo,
    output logic [7:0]         ido,
    output logic               nmio
);

    logic [7:0]      cause [NIRQ];
    logic [3:0]      level [NIRQ];
    logic [NIRQ-1:0] ie;
    logic [NIRQ-1:0] es;
    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] insvc;
    logic [NIRQ-1:0] ib;
    logic [3:0]      thresh;
    logic [5:0]      best_id;
    logic [3:0]      best_lvl;
    logic            rdy1;

    logic        cs;
    logic [9:0]  word;
    logic        is_ctrl;
    logic [5:0]  ctrl_n;
    logic [5:0]  src;
    logic        wr_fire;
    logic        eoi_wr;
    logic        trig_wr;
    logic        clrp_wr;
    logic        thr_wr;
    logic        ctrl_wr;
    logic        claim_fire;
    logic [3:0]  rl;
    logic [3:0]  win_lvl;
    logic [5:0]  win_id;
    logic [7:0]  best_cause;
    logic [31:0] ctrl_rd;
    logic [31:0] rdata;
    logic        unused_bits;

    assign cs      = bus.cyc_i & bus.stb_i & (bus.adr_i[31:12] == pIOAddress[31:12]);
    assign word    = bus.adr_i[11:2];
    assign is_ctrl = (bus.adr_i[11:8] == 4'h4);
    assign ctrl_n  = bus.adr_i[7:2];
    assign src     = bus.dat_i[5:0];

    assign wr_fire = cs & bus.wr_i;
    assign eoi_wr  = wr_fire & ~is_ctrl & (word == 10'h001);
    assign trig_wr = wr_fire & ~is_ctrl & (word == 10'h002);
    assign clrp_wr = wr_fire & ~is_ctrl & (word == 10'h003);
    assign thr_wr  = wr_fire & ~is_ctrl & (word == 10'h004);
    assign ctrl_wr = wr_fire & is_ctrl;

    // Claim acts only on the first cycle of a read so a held strobe claims once.
    assign claim_fire = cs & ~bus.wr_i & ~rdy1 & ~is_ctrl & (word == 10'h000) & (best_lvl != 4'd0);

    assign bus.ack_o = cs & (bus.wr_i | rdy1);
    assign bus.vol_o = cs;

    assign unused_bits = ^{bus.adr_i[1:0], bus.dat_i[31:18], bus.dat_i[15:12]};

    always_comb begin
        rl = thresh;
        for (int n = 0; n < NIRQ; n++) begin
            if (insvc[n] && level[n] > rl) rl = level[n];
        end
        // Source 0 is the NMI and never competes; >= lets the higher index win ties.
        win_lvl = 4'd0;
        win_id  = 6'd0;
        for (int n = 1; n < NIRQ; n++) begin
            if (ie[n] && (pend[n] | (~es[n] & irq_i[n])) && level[n] > rl && level[n] >= win_lvl) begin
                win_lvl = level[n];
                win_id  = 6'(n);
            end
        end
    end

    always_comb begin
        best_cause = 8'd0;
        ctrl_rd    = 32'd0;
        for (int n = 0; n < NIRQ; n++) begin
            if (best_id == 6'(n)) best_cause = cause[n];
            if (ctrl_n == 6'(n))
                ctrl_rd = {12'd0, insvc[n], pend[n], es[n], ie[n], 4'd0, level[n], cause[n]};
        end
        rdata = 32'd0;
        if (is_ctrl) begin
            rdata = ctrl_rd;
        end else begin
            case (word)
                10'h000: rdata = (best_lvl != 4'd0) ? {12'd0, best_lvl, 2'd0, best_id, best_cause} : 32'd0;
                10'h004: rdata = {28'd0, thresh};
                default: rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ie        <= '0;
            es        <= '1;
            pend      <= '0;
            insvc     <= '0;
            ib        <= '0;
            thresh    <= 4'd0;
            best_id   <= 6'd0;
            best_lvl  <= 4'd0;
            irqo      <= 4'd0;
            causeo    <= 8'd0;
            ido       <= 8'd0;
            nmio      <= 1'b0;
            bus.dat_o <= 32'd0;
            rdy1      <= 1'b0;
            for (int n = 0; n < NIRQ; n++) begin
                cause[n] <= 8'd0;
                level[n] <= 4'd8;
            end
        end else begin
            ib       <= irq_i;
            rdy1     <= cs;
            best_id  <= win_id;
            best_lvl <= win_lvl;
            irqo     <= best_lvl;
            causeo   <= best_cause;
            ido      <= {2'd0, best_id};
            nmio     <= irq_i[0] & ie[0];
            if (thr_wr) thresh <= bus.dat_i[3:0];
            if (!cs)
                bus.dat_o <= 32'd0;
            else if (!rdy1)
                bus.dat_o <= rdata;
            // Priorities: CLRP beats any set; a new edge/TRIG beats the claim clear;
            // claim beats EOI.
            for (int n = 0; n < NIRQ; n++) begin
                if (clrp_wr && src == 6'(n))
                    pend[n] <= 1'b0;
                else if ((es[n] && irq_i[n] && !ib[n]) || (trig_wr && src == 6'(n)))
                    pend[n] <= 1'b1;
                else if (claim_fire && best_id == 6'(n) && es[n])
                    pend[n] <= 1'b0;

                if (claim_fire && best_id == 6'(n))
                    insvc[n] <= 1'b1;
                else if (eoi_wr && src == 6'(n))
                    insvc[n] <= 1'b0;

                if (ctrl_wr && ctrl_n == 6'(n)) begin
                    cause[n] <= bus.dat_i[7:0];
                    level[n] <= bus.dat_i[11:8];
                    ie[n]    <= bus.dat_i[16];
                    es[n]    <= bus.dat_i[17];
                end
            end
        end
    end

endmodule

// File: tb/tb_bw_nested_pic.sv
// Directed bench for bw_nested_pic: stimulus pushes expectations, a negedge
// monitor pops them when a read acks or an output snapshot is requested.
module tb_bw_nested_pic;
    localparam int          NIRQ = 32;
    localparam logic [31:0] BASE = 32'hFF95_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NIRQ-1:0] irq = '0;
    logic [3:0]      irqo;
    logic [7:0]      causeo;
    logic [7:0]      ido;
    logic            nmio;
    logic            snap = 1'b0;
    logic [31:0]     obs;

    int vectors = 0;
    int miscompares = 0;

    string       name_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mask_q[$];

    bw_nested_pic_if bus();

    bw_nested_pic #(.pIOAddress(BASE), .NIRQ(NIRQ)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .irq_i (irq),
        .irqo  (irqo),
        .causeo(causeo),
        .ido   (ido),
        .nmio  (nmio)
    );

    always #5 clk = ~clk;

    // Output snapshot: {nmio, irqo, ido, causeo} in bits [20:0].
    assign obs = {11'd0, nmio, irqo, ido, causeo};

    always @(negedge clk) begin
        logic [31:0] act;
        logic        hit;
        hit = 1'b0;
        act = 32'd0;
        if (bus.ack_o && !bus.wr_i) begin
            hit = 1'b1;
            act = bus.dat_o;
        end else if (snap) begin
            hit = 1'b1;
            act = obs;
        end
        if (hit) begin
            vectors++;
            if (name_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got %08h, none expected", act);
            end else begin
                string       nm;
                logic [31:0] e;
                logic [31:0] m;
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                m  = mask_q.pop_front();
                if ((act & m) !== (e & m)) begin
                    miscompares++;
                    $display("FAIL %s: got %08h, expected %08h (mask %08h)", nm, act & m, e & m, m);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_val(input string nm, input logic [31:0] e, input logic [31:0] m);
        name_q.push_back(nm);
        exp_q.push_back(e);
        mask_q.push_back(m);
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] d, input logic [NIRQ-1:0] edge_in = '0);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.wr_i  = 1'b1;
        bus.adr_i = BASE | {20'd0, off};
        bus.dat_i = d;
        irq       = irq | edge_in;
        tick(1);
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.wr_i  = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [11:0] off, input logic [31:0] e,
                      input logic [NIRQ-1:0] edge_in = '0);
        expect_val(nm, e, 32'hFFFF_FFFF);
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.wr_i  = 1'b0;
        bus.adr_i = BASE | {20'd0, off};
        irq       = irq | edge_in;
        tick(2);
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        tick(1);
    endtask

    task automatic chk(input string nm, input logic [31:0] e, input logic [31:0] m = 32'h001F_FFFF);
        expect_val(nm, e, m);
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
    endtask

    task automatic pulse(input logic [NIRQ-1:0] m);
        irq = irq | m;
        tick(1);
        irq = irq & ~m;
    endtask

    localparam logic [11:0] CLAIM = 12'h000, EOI = 12'h004, TRIG = 12'h008,
                            CLRP = 12'h00C, THR = 12'h010;

    function automatic logic [11:0] ctrl(input int n);
        return 12'h400 + 12'(4 * n);
    endfunction

    initial begin
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.wr_i  = 1'b0;
        bus.adr_i = 32'd0;
        bus.dat_i = 32'd0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        rd("reset_ctrl5", ctrl(5), 32'h0002_0800);
        chk("reset_outputs", 32'h0000_0000);
        rd("ctrl_out_of_range", ctrl(40), 32'h0000_0000);
        rd("unmapped_read", 12'h020, 32'h0000_0000);

        // Priority: src3 lvl5 cause 33, src9 lvl2 cause 99, both edge
        wr(ctrl(3), 32'h0003_0533);
        wr(ctrl(9), 32'h0003_0299);
        pulse((32'd1 << 3) | (32'd1 << 9));
        tick(3);
        chk("prio_irq5_id3", 32'h0005_0333);
        rd("prio_claim3", CLAIM, 32'h0005_0333);
        tick(3);
        chk("prio_masked_by_insvc", 32'h0000_0000, 32'h000F_0000);
        rd("ctrl3_insvc", ctrl(3), 32'h000B_0533);
        wr(EOI, 32'd3);
        tick(3);
        chk("after_eoi3_id9", 32'h0002_0999);

        // Nesting
        rd("nest_claim9", CLAIM, 32'h0002_0999);
        tick(2);
        pulse(32'd1 << 3);
        tick(3);
        chk("nest_preempt5", 32'h0005_0333);
        rd("nest_claim3", CLAIM, 32'h0005_0333);
        pulse(32'd1 << 9);
        tick(3);
        chk("nest_blocked", 32'h0000_0000, 32'h000F_0000);
        wr(EOI, 32'd3);
        tick(3);
        chk("nest_9_still_insvc", 32'h0000_0000, 32'h000F_0000);
        wr(EOI, 32'd9);
        tick(3);
        chk("nest_9_refires", 32'h0002_0999);
        rd("nest_claim9_again", CLAIM, 32'h0002_0999);
        wr(EOI, 32'd9);

        // Tie and threshold
        wr(ctrl(4), 32'h0003_0644);
        wr(ctrl(7), 32'h0003_0677);
        pulse((32'd1 << 4) | (32'd1 << 7));
        tick(3);
        chk("tie_high_index", 32'h0006_0777);
        wr(THR, 32'd6);
        tick(3);
        chk("thresh6_blocks", 32'h0000_0000, 32'h000F_0000);
        rd("thresh_read", THR, 32'h0000_0006);
        wr(THR, 32'd5);
        tick(3);
        chk("thresh5_passes", 32'h0006_0777);
        wr(CLRP, 32'd4);
        wr(CLRP, 32'd7);
        wr(THR, 32'd0);
        tick(3);
        chk("clrp_idle", 32'h0000_0000, 32'h000F_0000);

        // CLRP coinciding with a new edge: clear wins
        wr(CLRP, 32'd4, 32'd1 << 4);
        irq[4] = 1'b0;
        tick(2);
        rd("clrp_beats_edge", ctrl(4), 32'h0003_0644);

        // Edge during claim: edge wins
        wr(TRIG, 32'd4);
        tick(3);
        chk("trig4_fires", 32'h0006_0444);
        rd("claim4_with_edge", CLAIM, 32'h0006_0444, 32'd1 << 4);
        irq[4] = 1'b0;
        rd("edge_beats_claim", ctrl(4), 32'h000F_0644);
        wr(EOI, 32'd4);
        tick(3);
        chk("eoi4_refires", 32'h0006_0444);
        wr(CLRP, 32'd4);
        tick(3);

        // Empty claim
        rd("empty_claim", CLAIM, 32'h0000_0000);
        rd("empty_claim_no_insvc", ctrl(4), 32'h0003_0644);

        // Level-sensitive latency: irqo at edge 2
        wr(ctrl(10), 32'h0001_03AA);
        tick(1);
        irq[10] = 1'b1;
        tick(1);
        chk("level_not_yet", 32'h0000_0000, 32'h000F_0000);
        chk("level_irq3", 32'h0003_0AAA);
        rd("level_claim10", CLAIM, 32'h0003_0AAA);
        irq[10] = 1'b0;
        wr(EOI, 32'd10);
        tick(3);
        rd("level_ctrl10_after_eoi", ctrl(10), 32'h0001_03AA);

        // NMI: source 0 level 8, never encoded
        wr(ctrl(0), 32'h0001_0855);
        irq[0] = 1'b1;
        tick(1);
        chk("nmi_asserted", 32'h0010_0000, 32'h001F_FF00);
        tick(3);
        chk("nmi_not_encoded", 32'h0010_0000, 32'h001F_FF00);
        irq[0] = 1'b0;
        tick(1);
        chk("nmi_released", 32'h0000_0000, 32'h001F_FF00);

        tick(2);
        while (name_q.size() > 0) begin
            string nm;
            logic [31:0] e;
            nm = name_q.pop_front();
            e  = exp_q.pop_front();
            void'(mask_q.pop_front());
            vectors++;
            miscompares++;
            $display("FAIL %s: no DUT response, expected %08h", nm, e);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
